// File: rtl/mem_responder.sv
// Purpose : arbitrates dcache/icache word requests onto a single-port, variable-latency RAM.
// Latency : grant registered in IDLE; min 2 cycles per word (grant + ACCESS), each word re-arbitrates.
// Backpr. : requester holds request and sees wait=1 until its ACCESS cycle; aborts on timeout/ERROR.
// Ports   : CLK/nRST; dcache dREN,dWEN,daddr,dstore -> dwait,dload; icache iREN,iaddr -> iwait,iload;
//           RAM ramREN,ramWEN,ramaddr,ramstore <- ramload,ramstate; stats d_acc_cnt,i_acc_cnt,timeout_err.
module mem_responder #(
   parameter int TIMEOUT      = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic [31:0] d_acc_cnt,
   output logic [31:0] i_acc_cnt,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   state_t        state, next_state;
   logic [WW-1:0] wait_cnt;
   logic [SW-1:0] starve_cnt;

   logic dreq, req_live, ram_access, ram_error;
   logic withdraw, err_abort, done, tmo;

   assign dreq       = dREN | dWEN;
   assign ram_access = (ramstate == RAM_ACCESS);
   assign ram_error  = (ramstate == RAM_ERROR);

   // Request of whichever side currently owns the RAM; 0 in IDLE.
   assign req_live  = (state == DSERV) ? dreq : (state == ISERV) ? iREN : 1'b0;
   assign withdraw  = (state != IDLE) & ~req_live;
   assign done      = req_live & ram_access;
   assign err_abort = req_live & ram_error;
   // Last permitted cycle without ACCESS: give up and free the RAM for the other side.
   assign tmo       = req_live & ~ram_access & ~ram_error & (wait_cnt == WAIT_LAST);

   assign dload = ramload;
   assign iload = ramload;

   always_comb begin
      next_state = state;
      dwait      = 1'b1;
      iwait      = 1'b1;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      case (state)
         IDLE: begin
            // Anti-starvation override first, then dcache has natural priority.
            if ((starve_cnt == STARVE_MAX) && iREN) next_state = ISERV;
            else if (dreq)                          next_state = DSERV;
            else if (iREN)                          next_state = ISERV;
         end
         DSERV: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;            // write wins when both bits are set
            ramREN   = dREN & ~dWEN;
            if (done) dwait = 1'b0;
            if (withdraw | err_abort | done | tmo) next_state = IDLE;
         end
         ISERV: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (done) iwait = 1'b0;
            if (withdraw | err_abort | done | tmo) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         starve_cnt  <= '0;
         d_acc_cnt   <= '0;
         i_acc_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= next_state;

         // Held at 0 in IDLE so every grant starts its timeout window fresh.
         if (state == IDLE)    wait_cnt <= '0;
         else if (!ram_access) wait_cnt <= wait_cnt + 1'b1;

         if ((state == DSERV) && done) d_acc_cnt <= d_acc_cnt + 32'd1;
         if ((state == ISERV) && done) i_acc_cnt <= i_acc_cnt + 32'd1;

         if (err_abort | tmo) timeout_err <= 1'b1;

         if ((state == DSERV) && done && iREN) begin
            if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
         end else if (((state == ISERV) && done) || ((state == IDLE) && !iREN)) begin
            starve_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : directed self-checking bench for mem_responder with a cycle-driven RAM latency model.
// Latency : RAM raises ACCESS on the ram_lat-th consecutive strobe cycle (or never / ERROR when forced).
// Backpr. : requests are dropped one cycle after their wait pulse, as a cache initiator would.
module tb_mem_responder;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        dREN, dWEN, iREN;
   logic [31:0] daddr, dstore, iaddr;
   logic        dwait, iwait;
   logic [31:0] dload, iload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;
   logic [31:0] d_acc_cnt, i_acc_cnt;
   logic        timeout_err;

   mem_responder #(.TIMEOUT(64), .STARVE_LIMIT(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate),
      .d_acc_cnt(d_acc_cnt), .i_acc_cnt(i_acc_cnt), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // RAM model knobs
   int          ram_lat;
   int          ram_cnt;
   bit          ram_stuck, ram_err;
   logic [31:0] ram_data;

   // Per-test observations
   int          cyc, n_rren, n_rwen, n_dlow, n_ilow, d_low_cyc, i_low_cyc;
   logic [31:0] last_dload, last_iload, last_raddr, last_rstore;
   bit          obs_dlow, obs_ilow;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_obs();
      n_rren = 0; n_rwen = 0; n_dlow = 0; n_ilow = 0;
      d_low_cyc = -1; i_low_cyc = -1;
      last_dload = '0; last_iload = '0; last_raddr = '0; last_rstore = '0;
   endtask

   // One clock: RAM model reacts to the strobes mid-cycle, then outputs are sampled.
   task automatic tick();
      @(negedge CLK);
      #1;
      if (ramREN || ramWEN) begin
         ram_cnt++;
         if (ram_err)                              ramstate = 2'd3;
         else if (!ram_stuck && ram_cnt >= ram_lat) ramstate = 2'd2;
         else                                      ramstate = 2'd1;
      end else begin
         ram_cnt  = 0;
         ramstate = 2'd0;
      end
      ramload = ram_data;
      #1;
      cyc++;
      obs_dlow = !dwait;
      obs_ilow = !iwait;
      if (ramREN) begin n_rren++; last_raddr = ramaddr; end
      if (ramWEN) begin n_rwen++; last_raddr = ramaddr; last_rstore = ramstore; end
      if (!dwait) begin n_dlow++; last_dload = dload; d_low_cyc = cyc; end
      if (!iwait) begin n_ilow++; last_iload = iload; i_low_cyc = cyc; end
   endtask

   // Issue one dcache word and wait for its completion pulse.
   task automatic d_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input int lat, input logic [31:0] rdata);
      bit got;
      got = 0;
      ram_lat = lat; ram_data = rdata;
      daddr = addr; dstore = data; dREN = rd; dWEN = wr;
      for (int k = 0; k < 100 && !got; k++) begin
         tick();
         if (obs_dlow) got = 1;
      end
      check_val("d_access_done", {31'd0, got}, 32'd1);
      tick();
      dREN = 1'b0; dWEN = 1'b0;
   endtask

   initial begin
      bit          done_d, done_i;
      int          nd;
      logic [7:0]  seq;
      logic [31:0] i_at_d5;

      nRST = 1'b0; dREN = 0; dWEN = 0; iREN = 0;
      daddr = '0; dstore = '0; iaddr = '0;
      ramload = '0; ramstate = 2'd0;
      ram_lat = 1; ram_cnt = 0; ram_stuck = 0; ram_err = 0; ram_data = '0;
      cyc = 0;
      clear_obs();
      #1;
      check_val("rst_dwait", {31'd0, dwait}, 32'd1);
      check_val("rst_iwait", {31'd0, iwait}, 32'd1);
      check_val("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
      check_val("rst_ramaddr", ramaddr, 32'd0);
      check_val("rst_ramstore", ramstore, 32'd0);
      check_val("rst_dcnt", d_acc_cnt, 32'd0);
      check_val("rst_icnt", i_acc_cnt, 32'd0);
      check_val("rst_terr", {31'd0, timeout_err}, 32'd0);
      tick(); tick();
      nRST = 1'b1;
      tick();

      // Single dcache read, ACCESS on 3rd strobe cycle
      clear_obs();
      d_access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
      check_val("rd_ren_cycles", n_rren, 32'd3);
      check_val("rd_dwait_pulses", n_dlow, 32'd1);
      check_val("rd_dload", last_dload, 32'hDEADBEEF);
      check_val("rd_addr", last_raddr, 32'h100);
      check_val("rd_iwait_quiet", n_ilow, 32'd0);
      check_val("rd_dcnt", d_acc_cnt, 32'd1);

      // Write with both dREN and dWEN set: write wins
      clear_obs();
      d_access(1'b1, 1'b1, 32'h200, 32'h12345678, 2, 32'h0);
      check_val("wr_wen_cycles", n_rwen, 32'd2);
      check_val("wr_ren_cycles", n_rren, 32'd0);
      check_val("wr_store", last_rstore, 32'h12345678);
      check_val("wr_addr", last_raddr, 32'h200);
      check_val("wr_dwait_pulses", n_dlow, 32'd1);
      check_val("wr_dcnt", d_acc_cnt, 32'd2);

      // Simultaneous requests: dcache first, icache after
      clear_obs();
      ram_lat = 1; ram_data = 32'hA5A5_0001;
      daddr = 32'h300; iaddr = 32'h400; dREN = 1; iREN = 1;
      done_d = 0; done_i = 0;
      for (int k = 0; k < 60 && !(done_d && done_i); k++) begin
         tick();
         if (done_d) dREN = 1'b0;
         if (done_i) iREN = 1'b0;
         if (obs_dlow) done_d = 1;
         if (obs_ilow) done_i = 1;
      end
      tick();
      dREN = 1'b0; iREN = 1'b0;
      check_val("arb_both_done", {30'd0, done_d, done_i}, 32'd3);
      check_val("arb_d_before_i", {31'd0, (d_low_cyc < i_low_cyc)}, 32'd1);
      check_val("arb_pulses", {n_dlow[15:0], n_ilow[15:0]}, {16'd1, 16'd1});
      check_val("arb_iload", last_iload, 32'hA5A5_0001);
      check_val("arb_last_addr", last_raddr, 32'h400);
      check_val("arb_dcnt", d_acc_cnt, 32'd3);
      check_val("arb_icnt", i_acc_cnt, 32'd1);

      // Starvation: both held; expect D D D D I D
      clear_obs();
      ram_lat = 1; daddr = 32'h500; iaddr = 32'h540;
      dREN = 1; iREN = 1;
      seq = '0; nd = 0; i_at_d5 = '1;
      for (int k = 0; k < 200 && (n_dlow + n_ilow) < 6; k++) begin
         tick();
         if (obs_dlow) begin
            seq = {seq[6:0], 1'b0};
            nd++;
            if (nd == 5) i_at_d5 = i_acc_cnt;
         end
         if (obs_ilow) seq = {seq[6:0], 1'b1};
      end
      tick();
      dREN = 1'b0; iREN = 1'b0;
      tick();
      check_val("starve_order", {26'd0, seq[5:0]}, 32'b000010);
      check_val("starve_icnt_at_d5", i_at_d5, 32'd2);
      check_val("starve_dcnt", d_acc_cnt, 32'd8);
      check_val("starve_icnt", i_acc_cnt, 32'd2);

      // Timeout: RAM stuck BUSY
      clear_obs();
      ram_stuck = 1; daddr = 32'h600; dREN = 1;
      for (int k = 0; k < 200 && !timeout_err; k++) tick();
      check_val("tmo_err", {31'd0, timeout_err}, 32'd1);
      check_val("tmo_strobe_cycles", n_rren, 32'd64);
      check_val("tmo_no_dwait", n_dlow, 32'd0);
      check_val("tmo_idle_strobe", {31'd0, ramREN}, 32'd0);
      check_val("tmo_dwait_high", {31'd0, dwait}, 32'd1);
      dREN = 1'b0; ram_stuck = 0;
      tick();
      clear_obs();
      d_access(1'b1, 1'b0, 32'h640, 32'h0, 2, 32'hCAFEF00D);
      check_val("post_tmo_dload", last_dload, 32'hCAFEF00D);
      check_val("post_tmo_dcnt", d_acc_cnt, 32'd9);
      check_val("post_tmo_sticky", {31'd0, timeout_err}, 32'd1);

      // Reset in the middle of an access
      ram_lat = 10; daddr = 32'h700; dREN = 1;
      tick(); tick(); tick();
      check_val("mid_strobe_before_rst", {31'd0, ramREN}, 32'd1);
      nRST = 1'b0;
      #1;
      check_val("mrst_ren", {31'd0, ramREN}, 32'd0);
      check_val("mrst_dwait", {31'd0, dwait}, 32'd1);
      check_val("mrst_counts", d_acc_cnt | i_acc_cnt, 32'd0);
      check_val("mrst_terr", {31'd0, timeout_err}, 32'd0);
      dREN = 1'b0;
      tick(); tick();
      nRST = 1'b1;
      tick();
      clear_obs();
      d_access(1'b1, 1'b0, 32'h740, 32'h0, 2, 32'h0BADF00D);
      check_val("post_rst_dload", last_dload, 32'h0BADF00D);
      check_val("post_rst_dcnt", d_acc_cnt, 32'd1);

      // Icache withdraws while being served
      clear_obs();
      ram_lat = 10; iaddr = 32'h800; iREN = 1;
      tick(); tick(); tick();
      iREN = 1'b0;
      tick(); tick();
      check_val("wd_iwait_quiet", n_ilow, 32'd0);
      check_val("wd_icnt", i_acc_cnt, 32'd0);
      check_val("wd_terr", {31'd0, timeout_err}, 32'd0);
      check_val("wd_strobe", {31'd0, ramREN}, 32'd0);

      // RAM ERROR aborts the access
      clear_obs();
      ram_err = 1; ram_lat = 3; daddr = 32'h900; dREN = 1;
      for (int k = 0; k < 50 && !timeout_err; k++) tick();
      dREN = 1'b0;
      tick();
      check_val("err_terr", {31'd0, timeout_err}, 32'd1);
      check_val("err_strobe_cycles", n_rren, 32'd1);
      check_val("err_no_dwait", n_dlow, 32'd0);
      check_val("err_dcnt", d_acc_cnt, 32'd1);
      ram_err = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cache-to-memory request protocol (dREN/dWEN/daddr/dstore/dload/dwait and iREN/iaddr/iload/iwait).
- Arbitrates between the data-cache and instruction-cache initiators and drives a single-port RAM with variable latency.
- Raises a wait signal to each requester until its word completes.
- Sits between both caches and RAM; it is the responder paired with the dcache's initiator FSM.

Parameters:
- TIMEOUT, 64: max cycles a grant may wait for RAM ACCESS before abort.
- STARVE_LIMIT, 4: consecutive dcache completions with iREN pending after which icache gets priority.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the completing cycle of a dcache access
- dload  out  32  dcache read data, valid when dwait low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the completing cycle of an icache access
- iload  out  32  icache read data, valid when iwait low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0=FREE 1=BUSY 2=ACCESS 3=ERROR
- d_acc_cnt  out  32  completed dcache accesses
- i_acc_cnt  out  32  completed icache accesses
- timeout_err  out  1  sticky: timeout or RAM ERROR seen

Behaviour:
- Clock/reset: one clock (CLK); nRST asynchronous, active-low.
- Reset values: state IDLE; dwait=iwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0; d_acc_cnt=i_acc_cnt=0; timeout_err=0; wait/starve counters 0. Reset mid-access aborts it immediately; no completion is reported.
- FSM states: IDLE, DSERV, ISERV. All RAM outputs are 0 in IDLE.
- IDLE, grant decision registered, so the first strobe appears the cycle after the request:
  - dreq=(dREN|dWEN).
  - starve==STARVE_LIMIT && iREN -> ISERV.
  - else dreq -> DSERV.
  - else iREN -> ISERV.
  - else stay in IDLE.
- DSERV:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN=1 -> ramWEN=1, ramREN=0 (write wins if both are set); else ramREN=1.
  - ramstate==ACCESS: dwait=0 that cycle, d_acc_cnt+1, -> IDLE.
  - Otherwise dwait=1.
- ISERV:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - ramstate==ACCESS: iwait=0, i_acc_cnt+1, starve cleared, -> IDLE.
- Non-granted requester: its wait stays 1 throughout.
- Outputs dload=iload=ramload, combinational.
- Minimum access is 2 cycles (IDLE grant + ACCESS cycle). Back-to-back words from one requester each pass through IDLE.
- Withdrawal: requester's request bits all 0 while served -> strobes dropped that cycle, -> IDLE, no count, no error.
- Timeout: wait counter clears on entering DSERV/ISERV and increments each non-ACCESS cycle. At TIMEOUT-1 without ACCESS -> timeout_err=1, -> IDLE, wait stays 1.
- ramstate==ERROR while serving -> timeout_err=1, -> IDLE, no completion. timeout_err clears only on reset.
- Starve counter:
  - +1 (saturating at STARVE_LIMIT) on each dcache completion where iREN=1.
  - Cleared on icache completion or in IDLE when iREN=0.
- Access counters wrap at 2^32 silently.
- Address/data inputs may change while served; RAM outputs follow them combinationally (requester must hold them stable).

Test Plan:
- Single dcache read: daddr=0x100, dREN=1; RAM ACCESS 3 cycles after strobe with ramload=0xDEADBEEF -> ramREN high 3 cycles; dwait low 1 cycle with dload=0xDEADBEEF; d_acc_cnt=1.
- Dcache write with dREN=dWEN=1, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait pulses low once.
- Simultaneous dREN and iREN in IDLE -> DSERV first; after dcache completion, ISERV; iwait low only after dwait pulse.
- Starvation: iREN held, dREN continuous for 6 accesses -> after 4 dcache completions the next grant is ISERV; i_acc_cnt=1 before the 5th dcache completion.
- Timeout: ramstate stuck BUSY, dREN=1 -> after 64 cycles timeout_err=1, state IDLE, dwait never low; a second request is still served normally.
- Reset mid-access: nRST low during DSERV -> ramREN=0 and dwait=1 asynchronously, counters 0; after release, a new request completes normally.
